dmem_scheduler: RTL

- Controller that shares the dual-port data memory between `NUM_REQ` requesters such as load/store, DMA and debug.
- Each cycle it grants up to two requests round-robin and maps them onto the memory's write/read port pair.
- It returns read data to the owning requester one cycle after grant.
- After reset it scrubs the whole memory to zero before accepting traffic, because the RAM has no reset.

---
 rtl/dmem_sched_pkg.sv | 22 ++
 rtl/dmem_rr_picker.sv | 27 ++
 rtl/dmem_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_sched_pkg.sv
// Shared constants and helpers for the data-memory scheduler.
package dmem_sched_pkg;

  localparam int unsigned ST_W = 1;
  localparam logic [ST_W-1:0] ST_INIT = 1'b0;
  localparam logic [ST_W-1:0] ST_RUN  = 1'b1;

  // Ceiling log2, never below 1 so a requester id always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  // Response-stage record: {active, requester id}.
  function automatic int unsigned rsp_rec_width(input int unsigned num_req);
    return 1 + clog2(num_req);
  endfunction

endpackage

// File: rtl/dmem_rr_picker.sv
// Rotating-priority picker: first set mask bit at or above base, wrapping.
module dmem_rr_picker #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] base,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           found
);

  // Scan from base upward modulo N and take the first candidate.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      if (!found && mask[(32'(base) + off) % N]) begin
        found                        = 1'b1;
        grant[(32'(base) + off) % N] = 1'b1;
        idx                          = IDW'((32'(base) + off) % N);
      end
    end
  end

endmodule

// File: rtl/dmem_scheduler.sv
// Shares a dual-port data memory between NUM_REQ requesters: scrubs the RAM
// after reset, then grants up to two requests per cycle round-robin.
module dmem_scheduler
  import dmem_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata,
  output logic                          init_done,
  output logic                          mem_wr_en1,
  output logic                          mem_wr_en2,
  output logic                          mem_rd_en1,
  output logic                          mem_rd_en2,
  output logic [ADDR_WIDTH-1:0]         mem_wr_addr1,
  output logic [ADDR_WIDTH-1:0]         mem_wr_addr2,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr1,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr2,
  output logic [DATA_WIDTH-1:0]         mem_data_in1,
  output logic [DATA_WIDTH-1:0]         mem_data_in2,
  input  logic [DATA_WIDTH-1:0]         mem_data_out1,
  input  logic [DATA_WIDTH-1:0]         mem_data_out2
);

  localparam int unsigned ID_W  = clog2(NUM_REQ);
  localparam int unsigned REC_W = rsp_rec_width(NUM_REQ);
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [ST_W-1:0]       state;
  logic [PTR_W-1:0]      scrub_ptr;
  logic [ID_W-1:0]       rr_ptr;
  logic [REC_W-1:0]      rsp_rec1, rsp_rec2;

  logic                  run, scrubbing, scrub_pair, scrub_last;
  logic [NUM_REQ-1:0]    mask1, mask2, conflict;
  logic [NUM_REQ-1:0]    grant1, grant2;
  logic [ID_W-1:0]       idx1, idx2, last_idx;
  logic                  found1, found2;
  logic                  we1, we2;
  logic [ADDR_WIDTH-1:0] addr1, addr2;
  logic [DATA_WIDTH-1:0] wdata1, wdata2;

  // Memory enables must read 0 while reset is held, so INIT activity is gated by rstn.
  assign run        = (state == ST_RUN);
  assign scrubbing  = (state == ST_INIT) && rstn;
  assign scrub_pair = (32'(scrub_ptr) + 1 < DEPTH);
  assign scrub_last = (32'(scrub_ptr) + 2 >= DEPTH);

  assign mask1 = run ? req_valid : '0;

  dmem_rr_picker #(.N(NUM_REQ), .IDW(ID_W)) u_pick1 (
    .mask  (mask1),
    .base  (rr_ptr),
    .grant (grant1),
    .idx   (idx1),
    .found (found1)
  );

  // Slot-1 request fields and the write/write same-address conflict mask for slot 2.
  always_comb begin
    we1      = found1 && req_we[idx1];
    addr1    = req_addr[int'(idx1)*ADDR_WIDTH +: ADDR_WIDTH];
    wdata1   = req_wdata[int'(idx1)*DATA_WIDTH +: DATA_WIDTH];
    conflict = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      conflict[i] = we1 && req_we[i] &&
                    (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == addr1);
    end
  end

  assign mask2 = mask1 & ~grant1 & ~conflict;

  dmem_rr_picker #(.N(NUM_REQ), .IDW(ID_W)) u_pick2 (
    .mask  (mask2),
    .base  (rr_ptr),
    .grant (grant2),
    .idx   (idx2),
    .found (found2)
  );

  // Slot-2 request fields.
  always_comb begin
    we2    = found2 && req_we[idx2];
    addr2  = req_addr[int'(idx2)*ADDR_WIDTH +: ADDR_WIDTH];
    wdata2 = req_wdata[int'(idx2)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign req_ready = grant1 | grant2;
  assign last_idx  = found2 ? idx2 : idx1;

  // Memory port mapping: scrub pairs in INIT, slot k onto port k in RUN.
  always_comb begin
    mem_wr_en1   = 1'b0;
    mem_wr_en2   = 1'b0;
    mem_rd_en1   = 1'b0;
    mem_rd_en2   = 1'b0;
    mem_wr_addr1 = '0;
    mem_wr_addr2 = '0;
    mem_rd_addr1 = '0;
    mem_rd_addr2 = '0;
    mem_data_in1 = '0;
    mem_data_in2 = '0;
    if (scrubbing) begin
      mem_wr_en1   = 1'b1;
      mem_wr_addr1 = ADDR_WIDTH'(scrub_ptr);
      if (scrub_pair) begin
        mem_wr_en2   = 1'b1;
        mem_wr_addr2 = ADDR_WIDTH'(scrub_ptr + PTR_W'(1));
      end
    end else if (run) begin
      if (found1) begin
        if (we1) begin
          mem_wr_en1   = 1'b1;
          mem_wr_addr1 = addr1;
          mem_data_in1 = wdata1;
        end else begin
          mem_rd_en1   = 1'b1;
          mem_rd_addr1 = addr1;
        end
      end
      if (found2) begin
        if (we2) begin
          mem_wr_en2   = 1'b1;
          mem_wr_addr2 = addr2;
          mem_data_in2 = wdata2;
        end else begin
          mem_rd_en2   = 1'b1;
          mem_rd_addr2 = addr2;
        end
      end
    end
  end

  // State, scrub pointer, round-robin pointer and response stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_INIT;
      scrub_ptr <= '0;
      rr_ptr    <= '0;
      init_done <= 1'b0;
      rsp_rec1  <= '0;
      rsp_rec2  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          scrub_ptr <= scrub_ptr + PTR_W'(2);
          if (scrub_last) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (found1) rr_ptr <= ID_W'((32'(last_idx) + 1) % NUM_REQ);
        end
        default: state <= ST_INIT;
      endcase
      rsp_rec1 <= {found1 && !we1, idx1};
      rsp_rec2 <= {found2 && !we2, idx2};
    end
  end

  // Route registered read data back to the requester recorded for each port.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rsp_rec1[REC_W-1] && (rsp_rec1[ID_W-1:0] == ID_W'(i))) begin
        rsp_valid[i]                         = 1'b1;
        rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_data_out1;
      end else if (rsp_rec2[REC_W-1] && (rsp_rec2[ID_W-1:0] == ID_W'(i))) begin
        rsp_valid[i]                         = 1'b1;
        rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_data_out2;
      end
    end
  end

endmodule
